// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic result stage: flag bit positions,
// condition-code encodings and the buffered entry layout.
package arith_pkg;

    localparam int unsigned FLAG_V = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_C = 0;

    localparam int unsigned ARITH_DATA_W = 32;
    localparam int unsigned ARITH_TAG_W  = 5;

    typedef enum logic [3:0] {
        EQ = 4'd0,  NE = 4'd1,  CS = 4'd2,  CC = 4'd3,
        MI = 4'd4,  PL = 4'd5,  VS = 4'd6,  VC = 4'd7,
        HI = 4'd8,  LS = 4'd9,  GE = 4'd10, LT = 4'd11,
        GT = 4'd12, LE = 4'd13, AL = 4'd14, NV = 4'd15
    } cond_e;

    typedef struct packed {
        logic [ARITH_DATA_W-1:0] result;
        logic [ARITH_TAG_W-1:0]  tag;
    } arith_entry_t;

endpackage

// File: rtl/arith_cond_eval.sv
// Combinational condition-code evaluation of a 4-bit condition select
// against the architectural {V,Z,N,C} flags.
module arith_cond_eval
    import arith_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] cond,
    output logic       cond_true
);

    logic v, z, n, c;

    assign v = flags[FLAG_V];
    assign z = flags[FLAG_Z];
    assign n = flags[FLAG_N];
    assign c = flags[FLAG_C];

    always_comb begin
        cond_true = 1'b0;
        unique case (cond_e'(cond))
            EQ: cond_true = z;
            NE: cond_true = !z;
            CS: cond_true = c;
            CC: cond_true = !c;
            MI: cond_true = n;
            PL: cond_true = !n;
            VS: cond_true = v;
            VC: cond_true = !v;
            HI: cond_true = c && !z;
            LS: cond_true = !c || z;
            GE: cond_true = (n == v);
            LT: cond_true = (n != v);
            GT: cond_true = !z && (n == v);
            LE: cond_true = z || (n != v);
            AL: cond_true = 1'b1;
            NV: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/arith_result_stage.sv
// Result stage after the ALU: 2-entry in-order skid buffer, flags register and
// condition evaluation. Optional sticky overflow: ARITH_RESULT_STICKY_OV_EN.
module arith_result_stage
    import arith_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [3:0]        in_status,
    input  logic              in_set_flags,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic [3:0]        flags,
    input  logic [3:0]        cond,
    output logic              cond_true,
    input  logic              sticky_clr,
    output logic              sticky_ov
);

    logic [DATA_W-1:0] mem_result [2];
    logic [TAG_W-1:0]  mem_tag    [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic [1:0]        count_next;
    logic              push;
    logic              pop;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        count_next = count;
        unique case ({push, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    // in_ready is registered from the next occupancy, so a full buffer
    // refuses input for the cycle in which it is being popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem_result[i] <= '0;
                mem_tag[i]    <= '0;
            end
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= '0;
            in_ready <= 1'b0;
        end else begin
            if (push) begin
                mem_result[wr_ptr] <= in_result;
                mem_tag[wr_ptr]    <= in_tag;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count    <= count_next;
            in_ready <= (count_next != 2'd2);
        end
    end

    assign out_valid  = (count != 2'd0);
    assign out_result = mem_result[rd_ptr];
    assign out_tag    = mem_tag[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= '0;
        end else if (push && in_set_flags) begin
            flags <= in_status;
        end
    end

`ifdef ARITH_RESULT_STICKY_OV_EN
    logic sticky_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else if (push && in_status[FLAG_V]) begin
            sticky_q <= 1'b1;
        end else if (sticky_clr) begin
            sticky_q <= 1'b0;
        end
    end

    assign sticky_ov = sticky_q;
`else
    logic unused_sticky_clr;

    assign unused_sticky_clr = sticky_clr;
    assign sticky_ov         = 1'b0;
`endif

    arith_cond_eval u_cond_eval (
        .flags     (flags),
        .cond      (cond),
        .cond_true (cond_true)
    );

endmodule

// File: tb/tb_arith_result_stage.sv
// Directed self-checking bench for arith_result_stage; expectations for the
// sticky overflow output follow ARITH_RESULT_STICKY_OV_EN.
module tb_arith_result_stage;
    import arith_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [3:0]  in_status;
    logic        in_set_flags;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic [3:0]  flags;
    logic [3:0]  cond;
    logic        cond_true;
    logic        sticky_clr;
    logic        sticky_ov;

    int passed = 0;
    int total  = 0;

`ifdef ARITH_RESULT_STICKY_OV_EN
    localparam logic STICKY_ON = 1'b1;
`else
    localparam logic STICKY_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    arith_result_stage #(.DATA_W(32), .TAG_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_status    (in_status),
        .in_set_flags (in_set_flags),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_tag      (out_tag),
        .flags        (flags),
        .cond         (cond),
        .cond_true    (cond_true),
        .sticky_clr   (sticky_clr),
        .sticky_ov    (sticky_ov)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cond(input string tag, input logic [3:0] sel, input logic exp);
        cond = sel;
        #1;
        check(tag, 32'(cond_true), 32'(exp));
    endtask

    task automatic offer(input logic [31:0] res, input logic [3:0] st, input logic setf,
                         input logic [4:0] tg);
        in_valid     = 1'b1;
        in_result    = res;
        in_status    = st;
        in_set_flags = setf;
        in_tag       = tg;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_result    = '0;
        in_status    = '0;
        in_set_flags = 1'b0;
        in_tag       = '0;
        out_ready    = 1'b1;
        cond         = 4'd0;
        sticky_clr   = 1'b0;

        // Reset state
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_sticky", 32'(sticky_ov), 32'd0);
        rst_n = 1'b1;
        step();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Zero result with Z and C set
        offer(32'h0000_0000, 4'b0101, 1'b1, 5'd3);
        step();
        in_valid = 1'b0;
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_out_result", out_result, 32'h0);
        check("t1_out_tag", 32'(out_tag), 32'd3);
        check("t1_flags", 32'(flags), 32'b0101);
        check_cond("t1_eq", EQ, 1'b1);
        check_cond("t1_cs", CS, 1'b1);
        check_cond("t1_hi", HI, 1'b0);
        check_cond("t1_ls", LS, 1'b1);

        // Negative overflowed result: V=1 N=1, so N==V
        offer(32'h8000_0000, 4'b1010, 1'b1, 5'd7);
        step();
        in_valid = 1'b0;
        check("t2_out_tag", 32'(out_tag), 32'd7);
        check("t2_out_result", out_result, 32'h8000_0000);
        check("t2_flags", 32'(flags), 32'b1010);
        check_cond("t2_vs", VS, 1'b1);
        check_cond("t2_lt", LT, 1'b0);
        check_cond("t2_ge", GE, 1'b1);
        check_cond("t2_gt", GT, 1'b1);
        check_cond("t2_mi", MI, 1'b1);
        check_cond("t2_le", LE, 1'b0);
        check_cond("t2_al", AL, 1'b1);
        check_cond("t2_nv", NV, 1'b0);
        step();
        check("t2_drained", 32'(out_valid), 32'd0);

        // Backpressure: fill, refuse third, drain in order
        out_ready = 1'b0;
        offer(32'h1111_1111, 4'b0000, 1'b0, 5'd1);
        step();
        check("bp_ready_after1", 32'(in_ready), 32'd1);
        offer(32'h2222_2222, 4'b0000, 1'b0, 5'd2);
        step();
        check("bp_ready_full", 32'(in_ready), 32'd0);
        check("bp_head1", 32'(out_tag), 32'd1);
        offer(32'h3333_3333, 4'b0000, 1'b0, 5'd3);
        step();
        check("bp_refused_ready", 32'(in_ready), 32'd0);
        check("bp_stable_tag", 32'(out_tag), 32'd1);
        check("bp_stable_result", out_result, 32'h1111_1111);
        check("bp_flags_kept", 32'(flags), 32'b1010);
        out_ready = 1'b1;
        step();
        check("bp_pop1_head", 32'(out_tag), 32'd2);
        check("bp_pop1_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_pop2_head", 32'(out_tag), 32'd3);
        check("bp_pop2_result", out_result, 32'h3333_3333);
        check("bp_pop2_valid", 32'(out_valid), 32'd1);
        step();
        check("bp_empty", 32'(out_valid), 32'd0);

        // Push without set_flags leaves flags alone
        offer(32'h0000_0001, 4'b0101, 1'b1, 5'd4);
        step();
        check("nf_flags_set", 32'(flags), 32'b0101);
        offer(32'hDEAD_BEEF, 4'b0010, 1'b0, 5'd9);
        step();
        in_valid = 1'b0;
        check("nf_flags_kept", 32'(flags), 32'b0101);
        check("nf_tag", 32'(out_tag), 32'd9);
        check("nf_result", out_result, 32'hDEAD_BEEF);
        check("nf_valid", 32'(out_valid), 32'd1);
        step();
        check("nf_empty", 32'(out_valid), 32'd0);

        // Sticky overflow
        offer(32'h0000_00AA, 4'b1000, 1'b0, 5'd10);
        step();
        in_valid = 1'b0;
        check("st_set", 32'(sticky_ov), 32'(STICKY_ON));
        check("st_flags_kept", 32'(flags), 32'b0101);
        offer(32'h0000_00BB, 4'b1000, 1'b0, 5'd11);
        sticky_clr = 1'b1;
        step();
        in_valid = 1'b0;
        check("st_set_wins", 32'(sticky_ov), 32'(STICKY_ON));
        step();
        sticky_clr = 1'b0;
        check("st_cleared", 32'(sticky_ov), 32'd0);
        step();
        check("st_drained", 32'(out_valid), 32'd0);

        // Asynchronous reset with two entries buffered
        out_ready = 1'b0;
        offer(32'h0000_0014, 4'b1111, 1'b1, 5'd20);
        step();
        offer(32'h0000_0015, 4'b1111, 1'b1, 5'd21);
        step();
        in_valid = 1'b0;
        check("ar_full", 32'(in_ready), 32'd0);
        check("ar_flags_pre", 32'(flags), 32'b1111);
        check("ar_sticky_pre", 32'(sticky_ov), 32'(STICKY_ON));
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", 32'(out_valid), 32'd0);
        check("ar_flags", 32'(flags), 32'd0);
        check("ar_in_ready", 32'(in_ready), 32'd0);
        check("ar_sticky", 32'(sticky_ov), 32'd0);
        check("ar_out_tag", 32'(out_tag), 32'd0);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        check("ar_release_ready", 32'(in_ready), 32'd1);
        check("ar_no_stale", 32'(out_valid), 32'd0);
        step();
        check("ar_still_empty", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
